// File: rtl/note_sequencer_if.sv
// CPU-side register port and peripheral-side write port of the note sequencer.
interface note_sequencer_if;
  logic [5:0]  cpu_address;
  logic [15:0] cpu_data_in;
  logic        cpu_write_enable;
  logic [15:0] cpu_data_out;
  logic [5:0]  per_address;
  logic [15:0] per_data;
  logic        per_write_enable;
  logic        busy;
  logic        fifo_full;

  modport master (
    output cpu_address, cpu_data_in, cpu_write_enable,
    input  cpu_data_out, per_address, per_data, per_write_enable, busy, fifo_full
  );

  modport slave (
    input  cpu_address, cpu_data_in, cpu_write_enable,
    output cpu_data_out, per_address, per_data, per_write_enable, busy, fifo_full
  );
endinterface

// File: rtl/note_sequencer.sv
// Plays (note, duration) entries from a CPU-filled FIFO onto the speaker register,
// timing each note in millisecond ticks and inserting a silence gap between notes.
module note_sequencer #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 12000,
  parameter int GAP_MS   = 10
) (
  input  logic             clk,
  input  logic             reset,
  note_sequencer_if.slave  bus
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      DEPTH_C   = 4'(DEPTH);
  localparam logic [3:0]      PTR_LAST  = 4'(DEPTH - 1);
  localparam logic [7:0]      GAP_C     = 8'(GAP_MS);
  localparam logic [5:0]      SPK_ADDR  = 6'd9;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, SILENCE, GAP, NEXT} state_t;

  state_t        state;
  logic [15:0]   mem [16];
  logic [3:0]    wr_ptr, rd_ptr, count;
  logic          overflow;
  logic [PW-1:0] presc;
  logic [7:0]    tick_cnt, dur;

  logic push_req, ctrl_wr, start_req, stop_req, stat_rd;
  logic full, empty, push_ok, tick, load_go;
  logic [15:0] head;

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == PTR_LAST) ? 4'd0 : p + 4'd1;
  endfunction

  function automatic logic last_tick(input logic [7:0] cnt, input logic [7:0] target);
    return ({1'b0, cnt} + 9'd1) == {1'b0, target};
  endfunction

  assign push_req  = bus.cpu_write_enable && (bus.cpu_address == 6'd10);
  assign ctrl_wr   = bus.cpu_write_enable && (bus.cpu_address == 6'd11);
  assign start_req = ctrl_wr && bus.cpu_data_in[0];
  assign stop_req  = ctrl_wr && bus.cpu_data_in[1];
  assign stat_rd   = !bus.cpu_write_enable && (bus.cpu_address == 6'd10);
  assign full      = (count == DEPTH_C);
  assign empty     = (count == 4'd0);
  assign push_ok   = push_req && !full;
  assign tick      = (presc == TICK_LAST);
  assign head      = mem[rd_ptr];
  // A load pops the head on the same edge that presents the note to the speaker.
  assign load_go   = !stop_req && !empty &&
                     (((state == IDLE) && start_req) || (state == NEXT));
  assign bus.fifo_full = full;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.cpu_data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      overflow         <= 1'b0;
      bus.cpu_data_out <= '0;
    end else begin
      if (stop_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
        if (load_go) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + {3'b0, push_ok} - {3'b0, load_go};
      end
      if (push_req && full) overflow <= 1'b1;
      else if (stat_rd)     overflow <= 1'b0;
      if (stat_rd) bus.cpu_data_out <= {8'b0, count, overflow, full, empty, bus.busy};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      presc                <= '0;
      tick_cnt             <= '0;
      dur                  <= '0;
      bus.per_write_enable <= 1'b0;
      bus.per_address      <= '0;
      bus.per_data         <= '0;
      bus.busy             <= 1'b0;
    end else begin
      bus.per_write_enable <= 1'b0;
      bus.per_address      <= '0;
      if (stop_req) begin
        // Abort from any active state silences the speaker; stop in IDLE only flushes.
        if (state != IDLE) begin
          bus.per_write_enable <= 1'b1;
          bus.per_address      <= SPK_ADDR;
          bus.per_data         <= '0;
        end
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else if (load_go) begin
        bus.per_write_enable <= 1'b1;
        bus.per_address      <= SPK_ADDR;
        bus.per_data         <= {8'b0, head[7:0]};
        dur                  <= head[15:8];
        presc                <= '0;
        tick_cnt             <= '0;
        state                <= LOAD;
        bus.busy             <= 1'b1;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          LOAD: state <= PLAY;
          PLAY: begin
            if (dur == 8'd0 || (tick && last_tick(tick_cnt, dur))) begin
              bus.per_write_enable <= 1'b1;
              bus.per_address      <= SPK_ADDR;
              bus.per_data         <= '0;
              state                <= SILENCE;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
              if (tick) tick_cnt <= tick_cnt + 8'd1;
            end
          end
          SILENCE: begin
            presc    <= '0;
            tick_cnt <= '0;
            state    <= (GAP_MS == 0) ? NEXT : GAP;
          end
          GAP: begin
            if (tick && last_tick(tick_cnt, GAP_C)) begin
              state <= NEXT;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
              if (tick) tick_cnt <= tick_cnt + 8'd1;
            end
          end
          NEXT: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_MS=1, DEPTH=8.
module tb_note_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  note_sequencer_if bus();
  note_sequencer #(.DEPTH(8), .TICK_DIV(4), .GAP_MS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cpu_address = a; bus.cpu_data_in = d; bus.cpu_write_enable = 1'b1;
    @(negedge clk);
    bus.cpu_write_enable = 1'b0; bus.cpu_address = 6'd0;
  endtask

  task automatic cpu_read(output logic [15:0] d);
    @(negedge clk);
    bus.cpu_address = 6'd10; bus.cpu_write_enable = 1'b0;
    @(negedge clk);
    d = bus.cpu_data_out; bus.cpu_address = 6'd0;
  endtask

  task automatic test_reset();
    logic [15:0] st;
    int writes;
    reset = 1'b1; #1 reset = 1'b0; #3;
    tests++;
    if ({bus.per_write_enable, bus.per_address, bus.per_data, bus.busy, bus.fifo_full, bus.cpu_data_out} !== '0) begin
      fails++; $display("FAIL reset_outputs: got we=%b addr=%0d data=%h busy=%b full=%b dout=%h, required all 0",
        bus.per_write_enable, bus.per_address, bus.per_data, bus.busy, bus.fifo_full, bus.cpu_data_out);
    end
    @(negedge clk) reset = 1'b1;
    cpu_read(st);
    tests++;
    if (st !== 16'h0002) begin fails++; $display("FAIL reset_status: got %h required 0002", st); end
    cpu_write(6'd10, 16'h0A48);
    cpu_write(6'd11, 16'h0001);
    repeat (3) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL reset_pre_busy: got %b required 1", bus.busy); end
    #2 reset = 1'b0; #1;
    tests++;
    if ({bus.per_write_enable, bus.per_address, bus.per_data, bus.busy, bus.fifo_full, bus.cpu_data_out} !== '0) begin
      fails++; $display("FAIL reset_midplay: got we=%b addr=%0d data=%h busy=%b dout=%h, required all 0",
        bus.per_write_enable, bus.per_address, bus.per_data, bus.busy, bus.cpu_data_out);
    end
    @(negedge clk) reset = 1'b1;
    writes = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.per_write_enable) writes++; end
    tests++;
    if (writes !== 0) begin fails++; $display("FAIL reset_no_write: got %0d writes required 0", writes); end
    cpu_read(st);
    tests++;
    if (st !== 16'h0002) begin fails++; $display("FAIL reset_status2: got %h required 0002", st); end
  endtask

  task automatic test_single_note();
    int k;
    cpu_write(6'd10, 16'h0345);
    cpu_write(6'd11, 16'h0001);
    tests++;
    if ({bus.per_write_enable, bus.per_address, bus.per_data, bus.busy} !== {1'b1, 6'd9, 16'd69, 1'b1}) begin
      fails++; $display("FAIL single_note_write: got we=%b addr=%0d data=%0d busy=%b required 1/9/69/1",
        bus.per_write_enable, bus.per_address, bus.per_data, bus.busy);
    end
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.per_write_enable) begin k = i; break; end
      if (bus.per_address !== 6'd0) k = -1;
    end
    tests++;
    if (k !== 13) begin fails++; $display("FAIL single_note_gap: got %0d cycles required 13", k); end
    tests++;
    if ({bus.per_address, bus.per_data} !== {6'd9, 16'd0}) begin
      fails++; $display("FAIL single_silence: got addr=%0d data=%h required 9/0000", bus.per_address, bus.per_data);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_next: got %b required 1", bus.busy); end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b required 0", bus.busy); end
  endtask

  task automatic test_fifo_full();
    logic [15:0] st;
    for (int i = 0; i < 9; i++) begin
      cpu_write(6'd10, 16'h0100 + 16'(i));
      if (i == 6) begin
        tests++;
        if (bus.fifo_full !== 1'b0) begin fails++; $display("FAIL full_after7: got %b required 0", bus.fifo_full); end
      end
      if (i == 7) begin
        tests++;
        if (bus.fifo_full !== 1'b1) begin fails++; $display("FAIL full_after8: got %b required 1", bus.fifo_full); end
      end
    end
    cpu_read(st);
    tests++;
    if (st !== 16'h008C) begin fails++; $display("FAIL overflow_status: got %h required 008C", st); end
    cpu_read(st);
    tests++;
    if (st !== 16'h0084) begin fails++; $display("FAIL overflow_cleared: got %h required 0084", st); end
    cpu_write(6'd11, 16'h0002);
    tests++;
    if (bus.per_write_enable !== 1'b0) begin fails++; $display("FAIL idle_stop_write: got %b required 0", bus.per_write_enable); end
    cpu_read(st);
    tests++;
    if (st !== 16'h0002) begin fails++; $display("FAIL idle_stop_flush: got %h required 0002", st); end
  endtask

  task automatic test_sequence();
    logic [15:0] seen [$];
    logic [15:0] exp [6] = '{16'd60, 16'd0, 16'd64, 16'd0, 16'd67, 16'd0};
    logic [15:0] st;
    int cyc;
    cpu_write(6'd10, 16'h013C);
    cpu_write(6'd10, 16'h0140);
    cpu_write(6'd10, 16'h0143);
    cpu_write(6'd11, 16'h0001);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      if (bus.per_write_enable) seen.push_back(bus.per_data);
      @(negedge clk); cyc++;
    end
    tests++;
    if (cyc >= 100 || seen.size() != 6) begin
      fails++; $display("FAIL seq_count: got %0d writes in %0d cycles required 6 before idle", seen.size(), cyc);
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (seen[i] !== exp[i]) begin fails++; $display("FAIL seq_write%0d: got %0d required %0d", i, seen[i], exp[i]); end
      end
    end
    tests++;
    if (cyc !== 33) begin fails++; $display("FAIL seq_length: got %0d busy cycles required 33", cyc); end
    cpu_read(st);
    tests++;
    if (st !== 16'h0002) begin fails++; $display("FAIL seq_idle_status: got %h required 0002", st); end
  endtask

  task automatic test_stop();
    logic [15:0] st;
    cpu_write(6'd10, 16'h0548);
    cpu_write(6'd10, 16'h0130);
    cpu_write(6'd11, 16'h0001);
    repeat (3) @(negedge clk);
    cpu_write(6'd11, 16'h0002);
    tests++;
    if ({bus.per_write_enable, bus.per_address, bus.per_data, bus.busy} !== {1'b1, 6'd9, 16'd0, 1'b0}) begin
      fails++; $display("FAIL stop_silence: got we=%b addr=%0d data=%h busy=%b required 1/9/0000/0",
        bus.per_write_enable, bus.per_address, bus.per_data, bus.busy);
    end
    @(negedge clk);
    tests++;
    if (bus.per_write_enable !== 1'b0) begin fails++; $display("FAIL stop_single_write: got %b required 0", bus.per_write_enable); end
    cpu_read(st);
    tests++;
    if (st !== 16'h0002) begin fails++; $display("FAIL stop_flush_status: got %h required 0002", st); end
    cpu_write(6'd11, 16'h0001);
    tests++;
    if ({bus.per_write_enable, bus.busy} !== 2'b00) begin
      fails++; $display("FAIL stop_start_empty: got we=%b busy=%b required 0/0", bus.per_write_enable, bus.busy);
    end
  endtask

  task automatic test_zero_and_stopstart();
    logic [15:0] st;
    int cyc;
    cpu_write(6'd10, 16'h0050);
    cpu_write(6'd11, 16'h0001);
    tests++;
    if ({bus.per_write_enable, bus.per_data} !== {1'b1, 16'd80}) begin
      fails++; $display("FAIL zero_note: got we=%b data=%0d required 1/80", bus.per_write_enable, bus.per_data);
    end
    @(negedge clk);
    tests++;
    if (bus.per_write_enable !== 1'b0) begin fails++; $display("FAIL zero_play: got %b required 0", bus.per_write_enable); end
    @(negedge clk);
    tests++;
    if ({bus.per_write_enable, bus.per_data} !== {1'b1, 16'd0}) begin
      fails++; $display("FAIL zero_silence: got we=%b data=%h required 1/0000", bus.per_write_enable, bus.per_data);
    end
    cyc = 0;
    while (bus.busy && cyc < 50) begin @(negedge clk); cyc++; end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL zero_idle: busy stuck after %0d cycles", cyc); end
    // stop+start while busy
    cpu_write(6'd10, 16'h0555);
    cpu_write(6'd10, 16'h0556);
    cpu_write(6'd11, 16'h0001);
    repeat (2) @(negedge clk);
    cpu_write(6'd11, 16'h0003);
    tests++;
    if ({bus.per_write_enable, bus.per_data, bus.busy} !== {1'b1, 16'd0, 1'b0}) begin
      fails++; $display("FAIL stopstart_busy: got we=%b data=%h busy=%b required 1/0000/0",
        bus.per_write_enable, bus.per_data, bus.busy);
    end
    cpu_read(st);
    tests++;
    if (st !== 16'h0002) begin fails++; $display("FAIL stopstart_busy_status: got %h required 0002", st); end
    // stop+start in IDLE with a queued entry: flush wins, nothing plays
    cpu_write(6'd10, 16'h0157);
    cpu_write(6'd11, 16'h0003);
    tests++;
    if ({bus.per_write_enable, bus.busy} !== 2'b00) begin
      fails++; $display("FAIL stopstart_idle: got we=%b busy=%b required 0/0", bus.per_write_enable, bus.busy);
    end
    cpu_read(st);
    tests++;
    if (st !== 16'h0002) begin fails++; $display("FAIL stopstart_idle_status: got %h required 0002", st); end
  endtask

  initial begin
    bus.cpu_address = 6'd0;
    bus.cpu_data_in = 16'd0;
    bus.cpu_write_enable = 1'b0;
    test_reset();
    test_single_note();
    test_fifo_full();
    test_sequence();
    test_stop();
    test_zero_and_stopstart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- CPU-programmable note sequencer sitting directly upstream of the peripherals block's speaker register (peripheral address 9).
- CPU pushes (note, duration) entries into a small FIFO, then issues start.
- Block autonomously writes each note to address 9, holds it for the programmed number of milliseconds, inserts a silence gap, and continues until the FIFO drains.
- Frees the CPU from software delay loops during tune playback.

Parameters:
- DEPTH, 8, FIFO entries; 2..15.
- TICK_DIV, 12000, clk cycles per 1 ms tick (12 MHz clk).
- GAP_MS, 10, silence ticks between notes; 0 means no gap.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_address  in  6  CPU peripheral address.
- cpu_data_in  in  16  CPU write data.
- cpu_write_enable  in  1  CPU write strobe; one write per asserted cycle.
- cpu_data_out  out  16  registered status read data.
- per_address  out  6  address driven to peripherals block.
- per_data  out  16  data driven to peripherals block.
- per_write_enable  out  1  one-cycle write strobe to peripherals block.
- busy  out  1  high while sequence playing.
- fifo_full  out  1  FIFO full flag.

Behaviour:
- Reset asserted: all outputs 0, FIFO empty, overflow flag 0, FSM IDLE, tick prescaler 0. Reset mid-playback aborts immediately; no silence write is issued.
- CPU register map (decoded on cpu_address):
  - 10 write: push entry. note = cpu_data_in[7:0], dur_ms = cpu_data_in[15:8].
  - 11 write: control. bit0 = start, bit1 = stop/flush.
  - 10 read (cpu_write_enable low): cpu_data_out <= {8'b0, count[3:0], overflow, full, empty, busy} on the next clk edge. The same read clears overflow.
  - Other addresses: ignored; cpu_data_out holds its value.
- FIFO:
  - Push while full is dropped and sets sticky overflow.
  - Full is evaluated on the pre-pop count, so a push coinciding with a pop while full is still dropped.
  - Push and pop in the same cycle when not full keeps count unchanged.
  - Pointers wrap modulo DEPTH.
- per_address is always 9 whenever per_write_enable is high; it is 0 otherwise.
- FSM states and transitions:
  - IDLE: busy=0. Start with FIFO non-empty goes to LOAD. Start with FIFO empty is ignored.
  - LOAD (1 cycle): pop head; per_write_enable=1, per_data={8'b0, note}; clear prescaler and tick counter; go to PLAY. busy=1 from this cycle.
  - PLAY: prescaler counts 0..TICK_DIV-1, emitting a tick at wrap. When tick count reaches dur_ms, go to SILENCE. If dur_ms=0, go to SILENCE on the next cycle.
  - SILENCE (1 cycle): per_write_enable=1, per_data=0. If GAP_MS=0, go to NEXT; else clear counters and go to GAP.
  - GAP: count GAP_MS ticks, then go to NEXT.
  - NEXT (1 cycle): FIFO non-empty goes to LOAD; empty goes to IDLE.
- Timing: a note write and its silence write are separated by exactly dur_ms*TICK_DIV + 1 cycles when dur_ms > 0.
- Stop (bit1) in any non-IDLE state:
  - Next cycle: one silence write (per_data=0), FIFO flushed, go to IDLE.
  - Stop in IDLE: only flushes the FIFO; no write is issued.
  - Stop and start in the same write: stop wins.
- Start while busy is ignored. Pushes during playback are accepted and played in order.
- Entries pushed after the FSM has entered IDLE require a new start.

Test Plan:
- Bench parameters: TICK_DIV=4, GAP_MS=1.
- Reset: assert reset low mid-PLAY -> all outputs 0 immediately; status read after release returns 0x0002 (empty only).
- Single note: push 0x0345 (note 69, 3 ms), start -> per_write_enable with per_data=69 at cycle 1; per_data=0 write exactly 13 cycles later; busy falls after 4-cycle gap + NEXT.
- FIFO full/overflow:
  - Push 9 entries with DEPTH=8 -> fifo_full=1 after the 8th push.
  - Status read returns 0x008C (count 8, overflow, full, not playing).
  - A second read shows overflow cleared (0x0084).
- Sequence order: push notes 60, 64, 67 with dur 1 each, start -> three note writes in order 60, 64, 67, each followed by a silence write; one LOAD per note; IDLE at end.
- Stop mid-play: during PLAY of note 72 write 0x0002 to address 11 -> next cycle a silence write, count=0, busy=0; later start is ignored (FIFO empty).
- Zero duration / simultaneous stop+start:
  - Push 0x0050 (note 80, dur 0), start -> note write, then silence write 2 cycles later.
  - Write 0x0003 while busy -> treated as stop.
